// File: rtl/array_source_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : array_source_if                                             |
// | Brief  : Request / array handoff bundle between the array source and |
// |          its consumer (sorter). master = source, slave = consumer.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface array_source_if #(
  parameter int N_ELEMS = 10,
  parameter int ELEM_W  = 4
) ();
  logic                        gen_req;
  logic                        arr_ready;
  logic                        arr_valid;
  logic [N_ELEMS*ELEM_W-1:0]   nums_arr;
  logic                        gen_busy;
  logic [7:0]                  gen_count;

  modport master (
    input  gen_req,
    input  arr_ready,
    output arr_valid,
    output nums_arr,
    output gen_busy,
    output gen_count
  );

  modport slave (
    output gen_req,
    output arr_ready,
    input  arr_valid,
    input  nums_arr,
    input  gen_busy,
    input  gen_count
  );
endinterface
`default_nettype wire

// File: rtl/array_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : array_source                                                |
// | Brief  : Fills N_ELEMS pseudo-random values (0..MAX_VAL) from a      |
// |          free-running 16-bit Galois LFSR on request and presents the |
// |          array on a stable packed bus with a valid/ready handshake.  |
// |          Optional macro ARRAY_SOURCE_UNIQUE_EN: reject candidates    |
// |          already present in the partial array (distinct values).    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module array_source #(
  parameter int          N_ELEMS = 10,
  parameter int          ELEM_W  = 4,
  parameter int          MAX_VAL = 9,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  array_source_if.master bus
);

  localparam int                  c_IDX_W    = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
  localparam int                  c_ARR_W    = N_ELEMS * ELEM_W;
  localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(N_ELEMS - 1);
  localparam logic [c_IDX_W-1:0]  c_ONE_IDX  = c_IDX_W'(1);
  localparam logic [ELEM_W-1:0]   c_MAX      = ELEM_W'(MAX_VAL);
  localparam logic [15:0]         c_MASK     = 16'hB400;
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [15:0]         c_SEED     = (SEED == 16'h0000) ? 16'h0001 : SEED;

  // Parameter sanity, caught at elaboration.
  generate
    if (MAX_VAL >= (1 << ELEM_W)) begin : g_bad_max_val
      $error("array_source: MAX_VAL must fit in ELEM_W bits");
    end
`ifdef ARRAY_SOURCE_UNIQUE_EN
    if (MAX_VAL + 1 < N_ELEMS) begin : g_bad_unique_range
      $error("array_source: too few legal values for a distinct array");
    end
`endif
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_lfsr,  w_lfsr_nxt;
  logic [c_IDX_W-1:0]   r_idx,   w_idx_nxt;
  logic [c_ARR_W-1:0]   r_work,  w_work_nxt;
  logic [c_ARR_W-1:0]   r_nums,  w_nums_nxt;
  logic [7:0]           r_count, w_count_nxt;

  logic [ELEM_W-1:0]    w_cand;
  logic                 w_in_range;
  logic                 w_dup;
  logic                 w_accept;

  // Galois step; runs in every state so request timing perturbs the sequence.
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_MASK : 16'h0000);

  assign w_cand     = r_lfsr[ELEM_W-1:0];
  assign w_in_range = (w_cand <= c_MAX);

`ifdef ARRAY_SOURCE_UNIQUE_EN
  // Only slots below the fill index hold values of the current array.
  logic [N_ELEMS-1:0] w_dup_vec;
  generate
    for (genvar j = 0; j < N_ELEMS; j++) begin : g_dup
      assign w_dup_vec[j] = (c_IDX_W'(j) < r_idx) &&
                            (r_work[j*ELEM_W +: ELEM_W] == w_cand);
    end
  endgenerate
  assign w_dup = |w_dup_vec;
`else
  assign w_dup = 1'b0;
`endif

  assign w_accept = w_in_range && !w_dup;

  // Next-state and datapath updates for the IDLE / FILL / PRESENT sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_work_nxt  = r_work;
    w_nums_nxt  = r_nums;
    w_count_nxt = r_count;

    case (r_state)
      S_IDLE: begin
        if (bus.gen_req) begin
          w_state_nxt = S_FILL;
          w_idx_nxt   = '0;
        end
      end

      S_FILL: begin
        // Requests are ignored here; a rejected candidate simply costs a cycle.
        if (w_accept) begin
          w_work_nxt[int'(r_idx)*ELEM_W +: ELEM_W] = w_cand;
          if (r_idx == c_LAST_IDX) begin
            w_nums_nxt  = w_work_nxt;
            w_state_nxt = S_PRESENT;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt   = r_idx + c_ONE_IDX;
          end
        end
      end

      S_PRESENT: begin
        // A handshake always counts, even when a new request arrives with it.
        if (bus.arr_ready) begin
          w_count_nxt = r_count + 8'd1;
        end
        if (bus.gen_req) begin
          w_state_nxt = S_FILL;
          w_idx_nxt   = '0;
        end else if (bus.arr_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any fill immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= c_SEED;
      r_idx   <= '0;
      r_work  <= '0;
      r_nums  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_idx   <= w_idx_nxt;
      r_work  <= w_work_nxt;
      r_nums  <= w_nums_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign bus.arr_valid = (r_state == S_PRESENT);
  assign bus.gen_busy  = (r_state == S_FILL);
  assign bus.nums_arr  = r_nums;
  assign bus.gen_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_array_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_array_source                                             |
// | Brief  : Self-checking bench for array_source. Expected arrays and   |
// |          fill latencies come from a reference generator that walks   |
// |          the LFSR sequence and applies the acceptance rules.         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_array_source;

  localparam int          N    = 10;
  localparam int          W    = 4;
  localparam int          MAXV = 9;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef logic [N*W-1:0] arr_t;

  typedef struct {
    logic req;
    logic rdy;
    logic exp_valid;
    logic exp_busy;
    int   dcount;
  } vec_t;

  logic clk;
  logic rst_n;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  m_count;
  arr_t        m_nums;

  array_source_if #(.N_ELEMS(N), .ELEM_W(W)) bus_if ();

  array_source #(
    .N_ELEMS (N),
    .ELEM_W  (W),
    .MAX_VAL (MAXV),
    .SEED    (SEED)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR: free-running from SEED, independent of the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  // Walk the LFSR from the first candidate, keep legal values until the
  // array is full; cycles = candidates examined = edges to arr_valid.
  function automatic arr_t predict(input logic [15:0] start, output int cycles);
    logic [15:0] s;
    logic [3:0]  c;
    arr_t        a;
    int          k;
    bit          ok;
    s = start; a = '0; k = 0; cycles = 0;
    while (k < N) begin
      c  = s[3:0];
      ok = (int'(c) <= MAXV);
`ifdef ARRAY_SOURCE_UNIQUE_EN
      for (int j = 0; j < k; j++) if (a[j*W +: W] == c) ok = 1'b0;
`endif
      if (ok) begin
        a[k*W +: W] = c;
        k++;
      end
      cycles++;
      s = lfsr_step(s);
    end
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request_edge(input logic rdy);
    bus_if.gen_req   = 1'b1;
    bus_if.arr_ready = rdy;
    tick();
    bus_if.gen_req   = 1'b0;
    bus_if.arr_ready = 1'b0;
    if (rdy) m_count = m_count + 8'd1;
  endtask

  task automatic handshake();
    bus_if.arr_ready = 1'b1;
    tick();
    bus_if.arr_ready = 1'b0;
    m_count = m_count + 8'd1;
    chk("hs_valid", bus_if.arr_valid, 0);
    chk("hs_busy",  bus_if.gen_busy,  0);
    chk("hs_count", bus_if.gen_count, m_count);
    chk("hs_nums_retained", bus_if.nums_arr, m_nums);
  endtask

  // Called just after the edge that started a fill.
  task automatic wait_fill(input bit collide);
    arr_t exp;
    int   cyc, n;
    bit   busy_ok, rng_ok;
`ifdef ARRAY_SOURCE_UNIQUE_EN
    logic [15:0] seen;
`endif
    exp = predict(m_lfsr, cyc);
    chk("fill_start_busy",  bus_if.gen_busy,  1);
    chk("fill_start_valid", bus_if.arr_valid, 0);
    n = 0; busy_ok = 1'b1;
    while (bus_if.arr_valid !== 1'b1 && n < 5000) begin
      if (collide && n == 2) bus_if.gen_req = 1'b1;
      tick();
      bus_if.gen_req = 1'b0;
      n++;
      if (bus_if.arr_valid !== 1'b1 && bus_if.gen_busy !== 1'b1) busy_ok = 1'b0;
    end
    chk("fill_latency",      n, cyc);
    chk("fill_busy_held",    busy_ok, 1);
    chk("fill_nums",         bus_if.nums_arr, exp);
    chk("fill_busy_cleared", bus_if.gen_busy, 0);
    chk("fill_count",        bus_if.gen_count, m_count);
    rng_ok = 1'b1;
    for (int j = 0; j < N; j++)
      if (int'(bus_if.nums_arr[j*W +: W]) > MAXV) rng_ok = 1'b0;
    chk("fill_range", rng_ok, 1);
`ifdef ARRAY_SOURCE_UNIQUE_EN
    seen = '0;
    for (int j = 0; j < N; j++) seen[bus_if.nums_arr[j*W +: W]] = 1'b1;
    chk("fill_permutation", seen, 16'h03FF);
`endif
    m_nums = exp;
  endtask

  vec_t tbl [4];

  initial begin
    bit stable;
    int k, choice;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 0};  // hold
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1};  // handoff -> IDLE
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 0};  // discard -> FILL
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1};  // handoff + refill

    bus_if.gen_req   = 1'b0;
    bus_if.arr_ready = 1'b0;
    m_count = '0;
    m_nums  = '0;

    // Asynchronous reset asserted between clock edges.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus_if.arr_valid, 0);
    chk("rst_async_busy",  bus_if.gen_busy,  0);
    chk("rst_async_nums",  bus_if.nums_arr,  0);
    chk("rst_async_count", bus_if.gen_count, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rst_idle", {bus_if.arr_valid, bus_if.gen_busy, bus_if.gen_count, bus_if.nums_arr}, 0);
    end

    // arr_ready in IDLE has no effect.
    bus_if.arr_ready = 1'b1;
    repeat (3) tick();
    bus_if.arr_ready = 1'b0;
    chk("idle_ready_count", bus_if.gen_count, 0);
    chk("idle_ready_valid", bus_if.arr_valid, 0);

    // Basic fill.
    request_edge(1'b0);
    wait_fill(1'b0);

    // Backpressure: array must stay bit-identical.
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus_if.arr_valid !== 1'b1 || bus_if.nums_arr !== m_nums) stable = 1'b0;
    end
    chk("backpressure_stable", stable, 1);
    handshake();

    // Request during FILL is ignored.
    request_edge(1'b0);
    wait_fill(1'b1);

    // PRESENT-state input combinations.
    for (int i = 0; i < 4; i++) begin
      bus_if.gen_req   = tbl[i].req;
      bus_if.arr_ready = tbl[i].rdy;
      tick();
      bus_if.gen_req   = 1'b0;
      bus_if.arr_ready = 1'b0;
      m_count = m_count + 8'(tbl[i].dcount);
      chk($sformatf("tbl%0d_valid", i), bus_if.arr_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_busy",  i), bus_if.gen_busy,  tbl[i].exp_busy);
      chk($sformatf("tbl%0d_count", i), bus_if.gen_count, m_count);
      chk($sformatf("tbl%0d_nums",  i), bus_if.nums_arr,  m_nums);
      if (tbl[i].exp_busy) begin
        wait_fill(1'b0);
      end else if (!tbl[i].exp_valid) begin
        request_edge(1'b0);
        wait_fill(1'b0);
      end
    end

    // Randomized hold times, handoff styles and collisions.
    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, 4);
      repeat (k) tick();
      chk("rand_hold_valid", bus_if.arr_valid, 1);
      choice = $urandom_range(0, 2);
      if (choice == 0) begin
        handshake();
        k = $urandom_range(0, 3);
        repeat (k) tick();
        request_edge(1'b0);
      end else if (choice == 1) begin
        request_edge(1'b0);
      end else begin
        request_edge(1'b1);
      end
      wait_fill($urandom_range(0, 1) == 1);
    end

    // Reset in the middle of a fill.
    request_edge(1'b0);
    repeat (5) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_fill_valid", bus_if.arr_valid, 0);
    chk("rst_fill_busy",  bus_if.gen_busy,  0);
    chk("rst_fill_nums",  bus_if.nums_arr,  0);
    chk("rst_fill_count", bus_if.gen_count, 0);
    m_count = '0;
    m_nums  = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_fill_idle", {bus_if.arr_valid, bus_if.gen_busy}, 0);
    request_edge(1'b0);
    wait_fill(1'b0);

    // Twenty consecutive handoffs.
    for (int i = 0; i < 20; i++) begin
      handshake();
      if (i < 19) begin
        request_edge(1'b0);
        wait_fill(1'b0);
      end
    end
    chk("count_20", bus_if.gen_count, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/array_source.md
Name: array_source

Overview:
- Upstream stage of the sorter: produces the unsorted array it consumes.
- On a user request (debounced button pulse), fills N_ELEMS pseudo-random elements in range 0..MAX_VAL from a free-running LFSR.
- Presents the array as a packed, stable bus with a valid/ready handshake; the sorter asserts ready when it latches the array and starts sorting.

Parameters:
- N_ELEMS, 10, number of array elements.
- ELEM_W, 4, bits per element.
- MAX_VAL, 9, largest legal element value; must be < 2^ELEM_W.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- gen_req  in  1  single-cycle request for a new array.
- arr_ready  in  1  consumer accepts the array this cycle.
- arr_valid  out  1  nums_arr holds a complete, unconsumed array.
- nums_arr  out  N_ELEMS*ELEM_W  packed array; element i at bits [i*ELEM_W +: ELEM_W].
- gen_busy  out  1  fill in progress.
- gen_count  out  8  arrays handed off since reset, wraps 255->0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, arr_valid=0, gen_busy=0, nums_arr=0, gen_count=0, idx=0, work buffer=0, lfsr=SEED.
- LFSR: 16-bit Galois, mask 16'hB400, advances every clock in every state (button timing supplies entropy). Never 0.
- Candidate = lfsr[ELEM_W-1:0]; accepted iff candidate <= MAX_VAL, else discarded and retried next cycle.
- FSM states IDLE, FILL, PRESENT:
  - IDLE: gen_req=1 -> FILL, idx=0, gen_busy=1 after that edge. Otherwise hold.
  - FILL: on an accepted candidate, work[idx]=candidate, idx+1. When element N_ELEMS-1 is accepted, copy work to nums_arr, go to PRESENT, arr_valid=1, gen_busy=0, all on the same edge. gen_req is ignored in FILL.
  - PRESENT: nums_arr and arr_valid held stable. arr_valid&arr_ready -> arr_valid=0, gen_count+1, go to IDLE. gen_req without arr_ready -> discard the array: arr_valid=0, go to FILL, idx=0. gen_req with arr_ready -> the handshake completes (count increments), then go directly to FILL.
- Latency: minimum N_ELEMS cycles from the edge that samples gen_req to arr_valid high. Each rejected candidate adds one cycle.
- nums_arr changes only on the FILL->PRESENT edge. It retains the last array after handoff, so the sorter may read it at any time.
- arr_ready outside PRESENT is ignored.
- Reset during any state aborts immediately to reset values. A partial array is never presented.

Optional Feature:
- Macro: ARRAY_SOURCE_UNIQUE_EN.
- Defined: a candidate is also rejected if it equals any work[j] with j < idx, so the presented array has distinct values. An elaboration-time check fails if MAX_VAL+1 < N_ELEMS. Duplicate comparison is combinational over the work buffer.
- Undefined: duplicates are allowed; only the range check applies.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-clock -> outputs 0 immediately (async), and remain 0 for 20 cycles with gen_req=0.
- Basic fill: gen_req pulse -> gen_busy=1 next cycle. arr_valid=1 no earlier than 10 cycles after; all 10 elements <= 9; gen_busy=0 when arr_valid rises.
- Backpressure: arr_ready=0 for 50 cycles after arr_valid -> nums_arr bit-identical and arr_valid=1 throughout. Then arr_ready=1 for one cycle -> arr_valid=0, gen_count 0->1.
- Request collisions: gen_req during FILL -> ignored, fill completes normally. gen_req alone in PRESENT -> arr_valid drops, new fill, gen_count unchanged. gen_req together with arr_ready -> gen_count+1 and a new fill starts.
- Reset mid-fill: rst_n low at idx=5 -> arr_valid=0, nums_arr=0. After release, a gen_req pulse produces a complete array.
- With ARRAY_SOURCE_UNIQUE_EN, N_ELEMS=10, MAX_VAL=9: 20 consecutive arrays -> each is a permutation of 0..9; gen_count=20.
